// File: rtl/convolution_index_gen.sv
// -----------------------------------------------------------------------------
// convolution_index_gen
// Loop sequencer for y[i] = sum_j x[j]*h[i-j]. Walks the output index i over
// 0..Lx+Ly-2 and, for each row, the inner index j over [j_start, j_end],
// offering (x addr = j, h addr = i-j) pairs to the MAC stage over valid/ready.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start_i             begin a run (sampled only in IDLE)
//   size_x_i, size_y_i  Lx / Ly, captured on accepted start
//   ready_i             MAC stage accepts the current pair
//   valid_o             pair on addr_x_o / addr_h_o is valid
//   addr_x_o, addr_h_o  x address (j) and h address (i-j)
//   i_o                 current output row (y write address)
//   j_fin_o             last j of the current row
//   acc_clr_o, y_wr_o   one-cycle accumulator clear / y write per row
//   busy_o, done_o      run in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module convolution_index_gen #(
    parameter int DATAWIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [DATAWIDTH-1:0] size_x_i,
    input  logic [DATAWIDTH-1:0] size_y_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [DATAWIDTH-1:0] addr_x_o,
    output logic [DATAWIDTH-1:0] addr_h_o,
    output logic [DATAWIDTH:0]   i_o,
    output logic [DATAWIDTH-1:0] j_fin_o,
    output logic                 acc_clr_o,
    output logic                 y_wr_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_ROW,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [DATAWIDTH:0] ONE = 1;
    localparam logic [DATAWIDTH:0] TWO = 2;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] lx_q, lx_d;
    logic [DATAWIDTH-1:0] ly_q, ly_d;
    logic [DATAWIDTH:0]   i_q, i_d;
    logic [DATAWIDTH-1:0] j_q, j_d;
    logic [DATAWIDTH-1:0] j_fin_q, j_fin_d;

    // Row bounds in DATAWIDTH+1 bits. Both Lx and Ly are >= 1 whenever these
    // are consumed, so the minus-one terms never wrap; the compare before the
    // subtraction keeps j_start from going negative.
    logic [DATAWIDTH:0] lx_m1, ly_m1, j_start_w, j_end_w;
    logic               last_row;

    always_comb begin
        lx_m1     = {1'b0, lx_q} - ONE;
        ly_m1     = {1'b0, ly_q} - ONE;
        j_start_w = (i_q > ly_m1) ? (i_q - ly_m1) : '0;
        j_end_w   = (i_q < lx_m1) ? i_q : lx_m1;
        // Last row is i = R-1 = Lx+Ly-2; the sum fits in DATAWIDTH+1 bits.
        last_row  = (i_q == ({1'b0, lx_q} + {1'b0, ly_q} - TWO));
    end

    always_comb begin
        state_d = state_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        i_d     = i_q;
        j_d     = j_q;
        j_fin_d = j_fin_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    lx_d = size_x_i;
                    ly_d = size_y_i;
                    i_d  = '0;
                    // An empty operand means an empty result: finish at once.
                    if (size_x_i == '0 || size_y_i == '0) state_d = S_DONE;
                    else                                  state_d = S_INIT_ROW;
                end
            end
            S_INIT_ROW: begin
                j_d     = DATAWIDTH'(j_start_w);
                j_fin_d = DATAWIDTH'(j_end_w);
                state_d = S_MAC;
            end
            S_MAC: begin
                if (ready_i) begin
                    if (j_q == j_fin_q) state_d = S_WRITE;
                    else                j_d     = j_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (last_row) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = S_INIT_ROW;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lx_q    <= '0;
            ly_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            j_fin_q <= '0;
        end else begin
            state_q <= state_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            i_q     <= i_d;
            j_q     <= j_d;
            j_fin_q <= j_fin_d;
        end
    end

    // Everything below is decoded from registered state only, so ready_i has
    // no combinational path to any output and a stalled pair stays put.
    assign valid_o   = (state_q == S_MAC);
    assign acc_clr_o = (state_q == S_INIT_ROW);
    assign y_wr_o    = (state_q == S_WRITE);
    assign done_o    = (state_q == S_DONE);
    assign busy_o    = (state_q != S_IDLE);
    assign addr_x_o  = j_q;
    // i-j never exceeds Ly-1, so modulo DATAWIDTH arithmetic is exact.
    assign addr_h_o  = i_q[DATAWIDTH-1:0] - j_q;
    assign i_o       = i_q;
    assign j_fin_o   = j_fin_q;

endmodule

// File: tb/tb_convolution_index_gen.sv
module tb_convolution_index_gen;

    logic       clk, rst, start_i, ready_i;
    logic [4:0] size_x_i, size_y_i;
    logic       valid_o, acc_clr_o, y_wr_o, busy_o, done_o;
    logic [4:0] addr_x_o, addr_h_o, j_fin_o;
    logic [5:0] i_o;

    convolution_index_gen #(.DATAWIDTH(5)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .size_x_i(size_x_i), .size_y_i(size_y_i), .ready_i(ready_i),
        .valid_o(valid_o), .addr_x_o(addr_x_o), .addr_h_o(addr_h_o),
        .i_o(i_o), .j_fin_o(j_fin_o), .acc_clr_o(acc_clr_o),
        .y_wr_o(y_wr_o), .busy_o(busy_o), .done_o(done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected per-cycle behaviour: kind 0 = row init, 1 = pair, 2 = write, 3 = done
    typedef struct {
        int kind;
        int ax;
        int ah;
        int i;
        int jf;
    } step_t;

    step_t expq[$];
    int    n_chk = 0, n_fail = 0;
    bit    check_on = 1'b0;
    int    edge_cnt = 0, busy_cnt = 0, done_edge = -1;
    int    rmode = 0, stalls = 0;
    int    obs_x[$], obs_h[$], obs_wi[$], obs_wj[$];

    // Reference: straight loops over the convolution index space.
    function automatic void build_model(int lx, int ly);
        step_t s;
        expq.delete();
        if (lx != 0 && ly != 0) begin
            for (int i = 0; i < lx + ly - 1; i++) begin
                int js, je;
                js = (i - (ly - 1) > 0) ? i - (ly - 1) : 0;
                je = (i < lx - 1) ? i : lx - 1;
                s = '{0, 0, 0, i, je};
                expq.push_back(s);
                for (int j = js; j <= je; j++) begin
                    s = '{1, j, i - j, i, je};
                    expq.push_back(s);
                end
                s = '{2, 0, 0, i, je};
                expq.push_back(s);
            end
        end
        s = '{3, 0, 0, 0, 0};
        expq.push_back(s);
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    // Ready driver: 0 = always ready, 1 = random, 2 = two stalls on pair (1,0)
    initial begin
        ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: ready_i = 1'b1;
                1: ready_i = ($urandom_range(0, 2) != 0);
                default: begin
                    if (valid_o && addr_x_o == 5'd1 && addr_h_o == 5'd0 && stalls < 2) begin
                        ready_i = 1'b0;
                        stalls++;
                    end else begin
                        ready_i = 1'b1;
                    end
                end
            endcase
        end
    end

    // Cycle-by-cycle compare against the head of the expected queue.
    initial forever begin
        logic [25:0] act, exp_v, msk;
        step_t s;
        @(negedge clk);
        if (check_on && !rst) begin
            act = {valid_o, acc_clr_o, y_wr_o, busy_o, done_o, i_o, j_fin_o, addr_x_o, addr_h_o};
            if (busy_o) busy_cnt++;
            if (done_o) done_edge = edge_cnt;
            if (expq.size() == 0) begin
                exp_v = '0;
                msk   = {5'h1f, 21'h0};
            end else begin
                s = expq[0];
                case (s.kind)
                    0: begin
                        exp_v = {5'b01010, 6'(s.i), 15'h0};
                        msk   = {5'h1f, 6'h3f, 15'h0};
                    end
                    1: begin
                        exp_v = {5'b10010, 6'(s.i), 5'(s.jf), 5'(s.ax), 5'(s.ah)};
                        msk   = '1;
                    end
                    2: begin
                        exp_v = {5'b00110, 6'(s.i), 5'(s.jf), 10'h0};
                        msk   = {16'hffff, 10'h0};
                    end
                    default: begin
                        exp_v = {5'b00011, 21'h0};
                        msk   = {5'h1f, 21'h0};
                    end
                endcase
                if (s.kind != 1 || ready_i) begin
                    if (s.kind == 1) begin
                        obs_x.push_back(int'(addr_x_o));
                        obs_h.push_back(int'(addr_h_o));
                    end
                    if (s.kind == 2) begin
                        obs_wi.push_back(int'(i_o));
                        obs_wj.push_back(int'(j_fin_o));
                    end
                    void'(expq.pop_front());
                end
            end
            n_chk++;
            if ((act & msk) != (exp_v & msk)) begin
                n_fail++;
                $display("FAIL cycle_model kind=%0d t=%0t: got %h expected %h (mask %h)",
                         (expq.size() == 0) ? -1 : s.kind, $time, act, exp_v, msk);
            end
        end
    end

    task automatic launch(input int lx, input int ly, input int mode);
        @(posedge clk);
        #1;
        size_x_i = 5'(lx);
        size_y_i = 5'(ly);
        rmode    = mode;
        stalls   = 0;
        start_i  = 1'b1;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        // Later size changes must not matter.
        size_x_i  = 5'($urandom);
        size_y_i  = 5'($urandom);
        edge_cnt  = 0;
        busy_cnt  = 0;
        done_edge = -1;
        obs_x.delete(); obs_h.delete(); obs_wi.delete(); obs_wj.delete();
        build_model(lx, ly);
    endtask

    task automatic finish_run(input int bound);
        for (int c = 0; c < bound; c++) begin
            @(posedge clk);
            if (expq.size() == 0) break;
        end
        chk("run_timeout_left", expq.size(), 0);
        expq.delete();
    endtask

    task automatic chk_pairs(input string name, input int ex[], input int eh[]);
        chk({name, "_npairs"}, obs_x.size(), ex.size());
        for (int k = 0; k < ex.size() && k < obs_x.size(); k++) begin
            chk({name, "_x"}, obs_x[k], ex[k]);
            chk({name, "_h"}, obs_h[k], eh[k]);
        end
    endtask

    initial begin
        int ex[], eh[];
        int lx, ly;
        rst = 1'b1; start_i = 1'b0; size_x_i = '0; size_y_i = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", int'({valid_o, acc_clr_o, y_wr_o, busy_o, done_o,
                                  i_o, j_fin_o, addr_x_o, addr_h_o}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        check_on = 1'b1;

        // 3 x 2, always ready
        launch(3, 2, 0);
        finish_run(200);
        ex = '{0, 0, 1, 1, 2, 2};
        eh = '{0, 1, 0, 1, 0, 1};
        chk_pairs("l3x2", ex, eh);
        chk("l3x2_nwr", obs_wi.size(), 4);
        for (int k = 0; k < 4 && k < obs_wi.size(); k++) begin
            chk("l3x2_wr_i", obs_wi[k], k);
            chk("l3x2_jfin", obs_wj[k], (k < 2) ? k : 2);
        end
        chk("l3x2_done_edge", done_edge, 14);

        // 1 x 1
        launch(1, 1, 0);
        finish_run(50);
        ex = '{0};
        eh = '{0};
        chk_pairs("l1x1", ex, eh);
        chk("l1x1_nwr", obs_wi.size(), 1);
        chk("l1x1_done_edge", done_edge, 3);

        // 3 x 2 with two stall cycles on pair (1,0)
        launch(3, 2, 2);
        finish_run(200);
        ex = '{0, 0, 1, 1, 2, 2};
        eh = '{0, 1, 0, 1, 0, 1};
        chk_pairs("stall", ex, eh);
        chk("stall_count", stalls, 2);
        chk("stall_done_edge", done_edge, 16);

        // Empty x: straight to done
        launch(0, 4, 0);
        finish_run(20);
        chk("zero_npairs", obs_x.size(), 0);
        chk("zero_nwr", obs_wi.size(), 0);
        chk("zero_busy_cycles", busy_cnt, 1);
        chk("zero_done_edge", done_edge, 0);

        // Widest case
        launch(31, 31, 0);
        finish_run(3000);
        chk("max_npairs", obs_x.size(), 961);
        chk("max_nwr", obs_wi.size(), 61);
        if (obs_wi.size() > 0) chk("max_last_wr_i", obs_wi[obs_wi.size()-1], 60);
        if (obs_x.size() > 0) begin
            chk("max_last_x", obs_x[obs_x.size()-1], 30);
            chk("max_last_h", obs_h[obs_h.size()-1], 30);
        end

        // Random sizes, random backpressure
        for (int r = 0; r < 10; r++) begin
            lx = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
            ly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
            launch(lx, ly, 1);
            finish_run(6000);
        end

        // Reset mid-MAC in row 2, then a fresh 2 x 2 run
        launch(3, 3, 1);
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 200 && !hit; c++) begin
                @(posedge clk);
                #2;
                if (valid_o && i_o == 6'd2) hit = 1'b1;
            end
            chk("rst_row2_reached", int'(hit), 1);
        end
        #1 rst = 1'b1;
        expq.delete();
        #1;
        chk("rst_abort_outputs", int'({valid_o, acc_clr_o, y_wr_o, busy_o, done_o,
                                      i_o, j_fin_o, addr_x_o, addr_h_o}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        launch(2, 2, 0);
        finish_run(100);
        ex = '{0, 0, 1, 1};
        eh = '{0, 1, 0, 1};
        chk_pairs("after_rst", ex, eh);
        chk("after_rst_wr0", (obs_wi.size() > 0) ? obs_wi[0] : -1, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
